// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes little-endian 32-bit words into
// instruction memory and releases the core once the frame checksum matches.
module imem_loader #(
  parameter int DEPTH   = 127,
  parameter int AW      = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_wa,
  output logic [31:0]   imem_wd,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]     DEPTH_W  = 16'(DEPTH);
  localparam logic [7:0]      SYNC     = 8'hA5;

  state_t        state_reg, state_next;
  logic [15:0]   len_reg, len_next;
  logic [15:0]   word_cnt_reg, word_cnt_next;
  logic [1:0]    byte_cnt_reg, byte_cnt_next;
  logic [31:0]   asm_reg, asm_next;
  logic [7:0]    xor_reg, xor_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          we_reg, we_next;
  logic [AW-1:0] wa_reg, wa_next;
  logic [31:0]   wd_reg, wd_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [1:0]    code_reg, code_next;
  logic          hold_reg, hold_next;
  logic          in_ready_reg;

  logic          accept;
  logic          active;
  logic [15:0]   len_full;
  logic [31:0]   lane_word;

  assign accept   = in_valid && in_ready_reg;
  assign active   = (state_reg == S_LEN0) || (state_reg == S_LEN1) ||
                    (state_reg == S_DATA) || (state_reg == S_CHK);
  assign len_full = {in_data, len_reg[7:0]};

  // Word as it looks with the incoming byte dropped into the current lane
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_word[8*gi +: 8] = (byte_cnt_reg == 2'(gi)) ? in_data : asm_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    word_cnt_next = word_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    asm_next      = asm_reg;
    xor_next      = xor_reg;
    tmo_next      = tmo_reg;
    we_next       = 1'b0;
    wa_next       = wa_reg;
    wd_next       = wd_reg;
    done_next     = done_reg;
    err_next      = err_reg;
    code_next     = code_reg;
    hold_next     = hold_reg;

    if (!active || accept) tmo_next = '0;
    else                   tmo_next = tmo_reg + 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (accept && in_data == SYNC) begin
          state_next = S_LEN0;
          xor_next   = 8'h00;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_next   = {8'h00, in_data};
          state_next = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_next = len_full;
          if (len_full > DEPTH_W) begin
            state_next = S_ERR;
            err_next   = 1'b1;
            code_next  = 2'd1;
          end else if (len_full == 16'd0) begin
            state_next = S_CHK;
          end else begin
            word_cnt_next = 16'd0;
            byte_cnt_next = 2'd0;
            state_next    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_next      = xor_reg ^ in_data;
          asm_next      = lane_word;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            we_next       = 1'b1;
            wa_next       = word_cnt_reg[AW-1:0];
            wd_next       = lane_word;
            word_cnt_next = word_cnt_reg + 16'd1;
            if (word_cnt_reg == len_reg - 16'd1) state_next = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == xor_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
            hold_next  = 1'b0;
          end else begin
            state_next = S_ERR;
            err_next   = 1'b1;
            code_next  = 2'd2;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (accept && in_data == SYNC) begin
          state_next = S_LEN0;
          done_next  = 1'b0;
          err_next   = 1'b0;
          code_next  = 2'd0;
          hold_next  = 1'b1;
          xor_next   = 8'h00;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // An accepted byte on the expiry edge takes priority over the timeout
    if (active && !accept && tmo_reg == TMO_LAST) begin
      state_next = S_ERR;
      done_next  = 1'b0;
      err_next   = 1'b1;
      code_next  = 2'd3;
      hold_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      xor_reg      <= '0;
      tmo_reg      <= '0;
      we_reg       <= 1'b0;
      wa_reg       <= '0;
      wd_reg       <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      code_reg     <= 2'd0;
      hold_reg     <= 1'b1;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      word_cnt_reg <= word_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      asm_reg      <= asm_next;
      xor_reg      <= xor_next;
      tmo_reg      <= tmo_next;
      we_reg       <= we_next;
      wa_reg       <= wa_next;
      wd_reg       <= wd_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      code_reg     <= code_next;
      hold_reg     <= hold_next;
      in_ready_reg <= 1'b1;
    end
  end

  assign in_ready = in_ready_reg;
  assign imem_we  = we_reg;
  assign imem_wa  = wa_reg;
  assign imem_wd  = wd_reg;
  assign cpu_hold = hold_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_code = code_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// randomized frames checked against a frame-level parsing model.
module tb_imem_loader;

  localparam int DEPTH   = 127;
  localparam int AW      = 7;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_wa;
  logic [31:0]   imem_wd;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
    .cpu_hold(cpu_hold), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          log_wa[$];
  logic [31:0] log_wd[$];
  logic [7:0]  frame_q[$];
  int          exp_wa[$];
  logic [31:0] exp_wd[$];
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;

  // Every strobe seen becomes one logged write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_wa.push_back(int'(imem_wa));
      log_wd.push_back(imem_wd);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (max_gap > 0 && i != frame_q.size() - 1) idle($urandom_range(max_gap, 0));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    log_wa.delete(); log_wd.delete();
  endtask

  // Frame-level model: locate sync, read N, slice words, XOR data, judge CHK
  task automatic build_expected();
    int p, n, base;
    logic [7:0]  x;
    logic [31:0] word;
    exp_wa.delete(); exp_wd.delete();
    p = 0;
    while (p < frame_q.size() && frame_q[p] != 8'hA5) p++;
    n = int'(frame_q[p+1]) + 256 * int'(frame_q[p+2]);
    if (n > DEPTH) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'd1;
      return;
    end
    x = 8'h00;
    base = p + 3;
    for (int w = 0; w < n; w++) begin
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        word = word | (32'(frame_q[base + 4*w + b]) << (8*b));
        x = x ^ frame_q[base + 4*w + b];
      end
      exp_wa.push_back(w);
      exp_wd.push_back(word);
    end
    if (frame_q[base + 4*n] == x) begin
      exp_done = 1'b1; exp_err = 1'b0; exp_code = 2'd0;
    end else begin
      exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'd2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0;
    idle(2);
    total_cnt++;
    if ({in_ready, imem_we, done, err, err_code, cpu_hold} !== 7'b0000001)
      $display("FAIL reset_flags: got %b want 0000001", {in_ready, imem_we, done, err, err_code, cpu_hold});
    else pass_cnt++;
    total_cnt++;
    if ({imem_wa, imem_wd} !== '0)
      $display("FAIL reset_wa_wd: got wa=%0d wd=%h want 0/0", imem_wa, imem_wd);
    else pass_cnt++;
    reset = 1'b0;
    idle(1);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", in_ready);
    else pass_cnt++;
    idle(3);
    total_cnt++;
    if ({in_ready, cpu_hold, done, err} !== 4'b1100)
      $display("FAIL idle_flags: got %b want 1100", {in_ready, cpu_hold, done, err});
    else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_load();
    logic [7:0] data [8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    logic [7:0] x;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      x = 8'h00;
      frame_q.delete();
      frame_q.push_back(8'hA5); frame_q.push_back(8'h02); frame_q.push_back(8'h00);
      foreach (data[i]) begin frame_q.push_back(data[i]); x = x ^ data[i]; end
      frame_q.push_back(k == 0 ? x : 8'h00);
      send_frame(0);
      total_cnt++;
      if ({done, err, err_code, cpu_hold} !== (k == 0 ? 5'b10000 : 5'b01101))
        $display("FAIL load%0d_status: got %b want %b", k, {done, err, err_code, cpu_hold},
                 (k == 0 ? 5'b10000 : 5'b01101));
      else pass_cnt++;
      total_cnt++;
      if (log_wa.size() != 2) $display("FAIL load%0d_wcount: got %0d want 2", k, log_wa.size());
      else pass_cnt++;
      if (log_wa.size() == 2) begin
        total_cnt++;
        if (log_wa[0] !== 0 || log_wd[0] !== 32'h00500093 || log_wa[1] !== 1 || log_wd[1] !== 32'h00100113)
          $display("FAIL load%0d_words: got (%0d,%h)(%0d,%h) want (0,00500093)(1,00100113)",
                   k, log_wa[0], log_wd[0], log_wa[1], log_wd[1]);
        else pass_cnt++;
      end
      $display("load frame chk=%h: done=%b err=%b code=%0d", frame_q[11], done, err, err_code);
    end
  endtask

  task automatic test_too_long();
    do_reset();
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
    total_cnt++;
    if ({done, err, err_code, cpu_hold} !== 5'b01011)
      $display("FAIL too_long_status: got %b want 01011", {done, err, err_code, cpu_hold});
    else pass_cnt++;
    idle(4);
    total_cnt++;
    if (log_wa.size() != 0 || err_code !== 2'd1)
      $display("FAIL too_long_after: got writes=%0d code=%0d want 0/1", log_wa.size(), err_code);
    else pass_cnt++;
    do_reset();
    send_byte(8'hA5); send_byte(8'h7F); send_byte(8'h00);
    idle(2);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL n_eq_depth: got err=%b want 0", err);
    else pass_cnt++;
    $display("too_long: code=1 path and N=DEPTH accept checked");
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    idle(TIMEOUT - 1);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL timeout_early: got err=%b want 0", err);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if ({done, err, err_code, cpu_hold} !== 5'b01111)
      $display("FAIL timeout_status: got %b want 01111", {done, err, err_code, cpu_hold});
    else pass_cnt++;
    total_cnt++;
    if (log_wa.size() != 1 || (log_wa.size() == 1 && (log_wa[0] !== 0 || log_wd[0] !== 32'h04030201)))
      $display("FAIL timeout_writes: got count=%0d want one write (0,04030201)", log_wa.size());
    else pass_cnt++;
    // Byte arriving on the expiry edge must win
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    idle(TIMEOUT - 1);
    send_byte(8'h22);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL timeout_byte_wins: got err=%b want 0", err);
    else pass_cnt++;
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h44);
    total_cnt++;
    if (done !== 1'b1 || log_wa.size() != 1 || (log_wa.size() == 1 && log_wd[0] !== 32'h44332211))
      $display("FAIL timeout_byte_wins_done: got done=%b writes=%0d want 1/1", done, log_wa.size());
    else pass_cnt++;
    $display("timeout: expiry and byte-wins checked");
  endtask

  task automatic test_garbage_zero();
    do_reset();
    frame_q.delete();
    frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    total_cnt++;
    if ({done, err, err_code, cpu_hold} !== 5'b10000 || log_wa.size() != 0)
      $display("FAIL garbage_zero: got %b writes=%0d want 10000/0", {done, err, err_code, cpu_hold}, log_wa.size());
    else pass_cnt++;
    send_byte(8'h3C);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL done_ignores_byte: got done=%b want 1", done);
    else pass_cnt++;
    send_byte(8'hA5);
    total_cnt++;
    if ({done, cpu_hold} !== 2'b01) $display("FAIL restart_clears: got done,hold=%b want 01", {done, cpu_hold});
    else pass_cnt++;
    $display("garbage+N=0: checked");
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    reset = 1'b1;
    idle(1);
    total_cnt++;
    if ({imem_we, done, err, cpu_hold, in_ready} !== 5'b00010)
      $display("FAIL midreset_flags: got %b want 00010", {imem_we, done, err, cpu_hold, in_ready});
    else pass_cnt++;
    idle(2);
    reset = 1'b0;
    idle(1);
    total_cnt++;
    if (log_wa.size() != 1) $display("FAIL midreset_partial: got writes=%0d want 1", log_wa.size());
    else pass_cnt++;
    log_wa.delete(); log_wd.delete();
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h00};
    build_expected();
    send_frame(0);
    idle(3);
    total_cnt++;
    if (log_wa.size() != exp_wa.size() || done !== exp_done)
      $display("FAIL midreset_reload: got writes=%0d done=%b want %0d/%b", log_wa.size(), done, exp_wa.size(), exp_done);
    else pass_cnt++;
    for (int i = 0; i < exp_wa.size() && i < log_wa.size(); i++) begin
      total_cnt++;
      if (log_wa[i] !== exp_wa[i] || log_wd[i] !== exp_wd[i])
        $display("FAIL midreset_word%0d: got (%0d,%h) want (%0d,%h)", i, log_wa[i], log_wd[i], exp_wa[i], exp_wd[i]);
      else pass_cnt++;
    end
    $display("reset mid-frame: reload checked");
  endtask

  task automatic test_random();
    int n;
    logic [7:0] g, x, b;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      frame_q.delete();
      repeat ($urandom_range(2, 0)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        frame_q.push_back(g);
      end
      frame_q.push_back(8'hA5);
      if ($urandom_range(7, 0) == 0) n = $urandom_range(400, DEPTH + 1);
      else n = $urandom_range(5, 0);
      frame_q.push_back(8'(n));
      frame_q.push_back(8'(n >> 8));
      if (n <= DEPTH) begin
        x = 8'h00;
        repeat (4 * n) begin b = 8'($urandom); frame_q.push_back(b); x = x ^ b; end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        frame_q.push_back(x);
      end
      log_wa.delete(); log_wd.delete();
      build_expected();
      send_frame(2);
      total_cnt++;
      if ({done, err, err_code, cpu_hold} !== {exp_done, exp_err, exp_code, ~exp_done})
        $display("FAIL rand%0d_status: got %b want %b", f, {done, err, err_code, cpu_hold},
                 {exp_done, exp_err, exp_code, ~exp_done});
      else pass_cnt++;
      total_cnt++;
      if (log_wa.size() != exp_wa.size())
        $display("FAIL rand%0d_wcount: got %0d want %0d", f, log_wa.size(), exp_wa.size());
      else pass_cnt++;
      for (int i = 0; i < exp_wa.size() && i < log_wa.size(); i++) begin
        total_cnt++;
        if (log_wa[i] !== exp_wa[i] || log_wd[i] !== exp_wd[i])
          $display("FAIL rand%0d_word%0d: got (%0d,%h) want (%0d,%h)", f, i, log_wa[i], log_wd[i], exp_wa[i], exp_wd[i]);
        else pass_cnt++;
      end
      $display("rand frame %0d: N=%0d writes=%0d done=%b code=%0d", f, n, log_wa.size(), done, err_code);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_too_long();
    test_timeout();
    test_garbage_zero();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
